// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio I/Q front end and channel filter.
// Holds the source FSM states and the Q10 quantisation helper.
package fm_radio_pkg;

    typedef enum logic [1:0] {
        READ_I,
        READ_Q,
        WRITE
    } iq_src_state_t;

    // Fractional bits of the filter chain fixed-point format.
    localparam int QUANT_BITS = 10;

    // Widest word the quantiser handles; callers cast to their own width.
    localparam int QMAX_W = 64;

    // Sign-extend the low sample_bits of sample, shift left by shift,
    // and keep only the low data_width bits (wraps, never saturates).
    function automatic logic [QMAX_W-1:0] quantize(
        input logic [QMAX_W-1:0] sample,
        input int                data_width,
        input int                sample_bits = 16,
        input int                shift       = QUANT_BITS
    );
        logic signed [QMAX_W-1:0] ext;
        logic        [QMAX_W-1:0] mask;
        ext  = $signed(sample << (QMAX_W - sample_bits));
        ext  = ext >>> (QMAX_W - sample_bits);
        mask = (data_width >= QMAX_W) ? '1 :
               ((QMAX_W'(1) << data_width) - QMAX_W'(1));
        return (QMAX_W'(ext) << shift) & mask;
    endfunction

endpackage

// File: rtl/iq_stream_source_if.sv
// Byte FIFO read side plus paired I/Q FIFO write side.
// master is the source block, slave is the surrounding FIFOs.
interface iq_stream_source_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) ();

    logic [BYTE_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;

    logic [DATA_WIDTH-1:0] i_out;
    logic                  i_wr_en;
    logic                  i_full;

    logic [DATA_WIDTH-1:0] q_out;
    logic                  q_wr_en;
    logic                  q_full;

    modport master (
        input  in_dout,
        input  in_empty,
        output in_rd_en,
        output i_out,
        output i_wr_en,
        input  i_full,
        output q_out,
        output q_wr_en,
        input  q_full
    );

    modport slave (
        output in_dout,
        output in_empty,
        input  in_rd_en,
        input  i_out,
        input  i_wr_en,
        output i_full,
        input  q_out,
        input  q_wr_en,
        output q_full
    );

endinterface

// File: rtl/iq_stream_source.sv
// Assembles little-endian byte pairs into I/Q samples, quantises them
// to Q10 and pushes each pair into the I and Q FIFOs together.
module iq_stream_source #(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int SAMPLE_BYTES = 2,
    parameter int QUANT_BITS   = fm_radio_pkg::QUANT_BITS
) (
    input  logic                clock,
    input  logic                reset,
    iq_stream_source_if.master  bus,
    output logic [31:0]         sample_count
);

    import fm_radio_pkg::*;

    localparam int SW = SAMPLE_BYTES * BYTE_WIDTH;
    localparam int CW = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_BYTES - 1);

    iq_src_state_t state, state_d;

    logic [CW-1:0] byte_cnt, byte_cnt_d;
    logic [SW-1:0] i_reg, i_reg_d;
    logic [SW-1:0] q_reg, q_reg_d;
    logic [31:0]   count_d;
    logic          out_full;
    logic          pop;

    // Next state, byte assembly and FIFO strobes; all quiet in reset.
    always_comb begin
        state_d      = state;
        byte_cnt_d   = byte_cnt;
        i_reg_d      = i_reg;
        q_reg_d      = q_reg;
        count_d      = sample_count;
        pop          = 1'b0;
        out_full     = bus.i_full | bus.q_full;
        bus.i_wr_en  = 1'b0;
        bus.q_wr_en  = 1'b0;
        bus.i_out    = '0;
        bus.q_out    = '0;
        if (reset) begin
            unique case (state)
                READ_I: begin
                    if (!bus.in_empty) begin
                        pop = 1'b1;
                        i_reg_d[byte_cnt*BYTE_WIDTH +: BYTE_WIDTH] =
                            bus.in_dout;
                        if (byte_cnt == LAST) begin
                            byte_cnt_d = '0;
                            state_d    = READ_Q;
                        end else begin
                            byte_cnt_d = byte_cnt + CW'(1);
                        end
                    end
                end
                READ_Q: begin
                    if (!bus.in_empty) begin
                        pop = 1'b1;
                        q_reg_d[byte_cnt*BYTE_WIDTH +: BYTE_WIDTH] =
                            bus.in_dout;
                        if (byte_cnt == LAST) begin
                            byte_cnt_d = '0;
                            state_d    = WRITE;
                        end else begin
                            byte_cnt_d = byte_cnt + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (!out_full) begin
                        bus.i_wr_en = 1'b1;
                        bus.q_wr_en = 1'b1;
                        bus.i_out   = DATA_WIDTH'(quantize(
                            QMAX_W'(i_reg), DATA_WIDTH, SW, QUANT_BITS));
                        bus.q_out   = DATA_WIDTH'(quantize(
                            QMAX_W'(q_reg), DATA_WIDTH, SW, QUANT_BITS));
                        count_d     = sample_count + 32'd1;
                        state_d     = READ_I;
                    end
                end
                default: begin
                    state_d    = READ_I;
                    byte_cnt_d = '0;
                end
            endcase
        end
        bus.in_rd_en = pop;
    end

    // State, assembly registers and pair counter; reset drops partials.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= READ_I;
            byte_cnt     <= '0;
            i_reg        <= '0;
            q_reg        <= '0;
            sample_count <= '0;
        end else begin
            state        <= state_d;
            byte_cnt     <= byte_cnt_d;
            i_reg        <= i_reg_d;
            q_reg        <= q_reg_d;
            sample_count <= count_d;
        end
    end

endmodule

// File: tb/tb_iq_stream_source.sv
// Randomised scoreboard bench for iq_stream_source.
// Byte FIFO and full flags are modelled; writes are checked in order.
module tb_iq_stream_source;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sample_count;

    always #5 clock = ~clock;

    iq_stream_source_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus ();

    iq_stream_source #(
        .DATA_WIDTH(32),
        .BYTE_WIDTH(8),
        .SAMPLE_BYTES(2),
        .QUANT_BITS(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .sample_count(sample_count)
    );

    // byte FIFO contents (main pushes, monitor advances rd_idx)
    logic [7:0]  byte_mem[$];
    int          rd_idx = 0;
    // expected pairs (main pushes, monitor advances exp_rd)
    logic [31:0] exp_i[$];
    logic [31:0] exp_q[$];
    int          exp_rd = 0;
    // deferred checks posted by main, evaluated by monitor
    string       chk_name[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];
    int          chk_rd = 0;

    int pop_cyc[$];
    int pops = 0;
    int writes = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int seen_pops = 0;
    int gap_left = 0;

    bit gap_mode = 0;
    bit force_i_full = 0;
    bit force_q_full = 0;
    bit rand_full = 0;
    int stall_pct = 0;

    int vectors = 0;
    int miscompares = 0;

    // Reference: 16-bit signed little-endian value times 2^10, mod 2^32.
    function automatic logic [31:0] ref_word(input logic [7:0] lo,
                                             input logic [7:0] hi);
        shortint v;
        v = shortint'({hi, lo});
        return 32'(int'(v) * 1024);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic post(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
        chk_name.push_back(name);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic push_raw(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        byte_mem.push_back(a);
        byte_mem.push_back(b);
        byte_mem.push_back(c);
        byte_mem.push_back(d);
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        push_raw(a, b, c, d);
        exp_i.push_back(ref_word(a, b));
        exp_q.push_back(ref_word(c, d));
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((rd_idx < byte_mem.size() || exp_rd < exp_i.size())
               && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= budget) post({name, "_timeout"}, 32'd1, 32'd0);
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic wait_pops(input string name, input int target,
                             input int budget);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= budget) post({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Input/full driver: FIFO head, random or gap stalls, full flags.
    always @(posedge clock) begin
        bit stall;
        #1;
        if (pops != seen_pops) begin
            seen_pops = pops;
            if (gap_mode) gap_left = 3;
        end
        stall = 1'b0;
        if (gap_left > 0) begin
            stall = 1'b1;
            gap_left--;
        end else if (stall_pct > 0 &&
                     $urandom_range(0, 99) < stall_pct) begin
            stall = 1'b1;
        end
        bus.in_empty = (rd_idx >= byte_mem.size()) || stall;
        bus.in_dout  = (rd_idx < byte_mem.size()) ? byte_mem[rd_idx]
                                                  : 8'($urandom);
        bus.i_full   = force_i_full |
                       (rand_full && $urandom_range(0, 3) == 0);
        bus.q_full   = force_q_full |
                       (rand_full && $urandom_range(0, 3) == 0);
    end

    // Monitor: FIFO pop model, scoreboard compare, posted checks.
    always @(negedge clock) begin
        cyc++;
        while (chk_rd < chk_name.size()) begin
            chk(chk_name[chk_rd], chk_act[chk_rd], chk_exp[chk_rd]);
            chk_rd++;
        end
        if (!reset) begin
            chk("reset_strobes",
                {29'd0, bus.in_rd_en, bus.i_wr_en, bus.q_wr_en}, 32'd0);
            chk("reset_data", bus.i_out | bus.q_out, 32'd0);
            rd_idx = byte_mem.size();
            exp_rd = exp_i.size();
            writes = 0;
        end else begin
            chk("wr_en_pair", {31'd0, bus.i_wr_en}, {31'd0, bus.q_wr_en});
            if (bus.in_empty) begin
                chk("rd_while_empty", {31'd0, bus.in_rd_en}, 32'd0);
            end else if (bus.in_rd_en) begin
                rd_idx++;
                pops++;
                pop_cyc.push_back(cyc);
            end
            if (bus.i_wr_en || bus.q_wr_en) begin
                chk("wr_while_full", {30'd0, bus.i_full, bus.q_full}, 32'd0);
                if (exp_rd >= exp_i.size()) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("i_out", bus.i_out, exp_i[exp_rd]);
                    chk("q_out", bus.q_out, exp_q[exp_rd]);
                    exp_rd++;
                end
                chk("count_at_write", sample_count, 32'(writes));
                writes++;
                last_wr_cyc = cyc;
            end else begin
                chk("idle_out_zero", bus.i_out | bus.q_out, 32'd0);
            end
        end
    end

    initial begin
        int p0;
        int p1;
        int w1;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        post("reset_count", sample_count, 32'd0);

        // back-to-back pair, latency from first pop to write
        p0 = pops;
        push_pair(8'h34, 8'h12, 8'hCD, 8'hAB);
        drain("t1", 100);
        if (pop_cyc.size() > p0)
            post("t1_latency", 32'(last_wr_cyc - pop_cyc[p0]), 32'd4);
        else
            post("t1_no_pop", 32'd1, 32'd0);
        post("t1_count", sample_count, 32'd1);

        // three empty cycles between every byte
        gap_mode = 1'b1;
        push_pair(8'h34, 8'h12, 8'hCD, 8'hAB);
        drain("t2", 200);
        gap_mode = 1'b0;
        post("t2_count", sample_count, 32'd2);

        // q_full held in WRITE with input bytes still available
        force_q_full = 1'b1;
        p0 = pops;
        push_pair(8'h34, 8'h12, 8'hCD, 8'hAB);
        push_pair(8'h11, 8'h22, 8'h33, 8'h44);
        wait_pops("t3_fill", p0 + 4, 100);
        p1 = pops;
        w1 = writes;
        repeat (10) @(negedge clock);
        #1;
        post("t3_hold_pops", 32'(pops), 32'(p1));
        post("t3_hold_writes", 32'(writes), 32'(w1));
        force_q_full = 1'b0;
        drain("t3", 200);
        post("t3_count", sample_count, 32'd4);

        // max positive / min negative
        push_pair(8'hFF, 8'h7F, 8'h00, 8'h80);
        drain("t4", 100);
        post("t4_count", sample_count, 32'd5);

        // reset after three bytes of a pair
        p0 = pops;
        push_raw(8'h34, 8'h12, 8'hCD, 8'hAB);
        wait_pops("t5_fill", p0 + 3, 100);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        push_pair(8'h01, 8'h00, 8'h02, 8'h00);
        drain("t5", 100);
        post("t5_count", sample_count, 32'd1);

        // random traffic from a fresh count
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        rand_full = 1'b1;
        stall_pct = 30;
        for (int k = 0; k < 1000; k++) begin
            push_pair(8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom));
        end
        drain("rand", 60000);
        post("rand_count", sample_count, 32'd1000);

        repeat (2) @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
